// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } seg_state_e;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    localparam int unsigned MAX_DIGITS = 32;
    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin_hex.sv
// 4-bit to active-low 7-segment decoder, bit order {a,b,c,d,e,f,g}.
module bin_hex (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o_c
);

    always_comb begin
        seg_o_c = 7'h7F;
        case (nibble_i)
            4'h0: seg_o_c = 7'h01;
            4'h1: seg_o_c = 7'h4F;
            4'h2: seg_o_c = 7'h12;
            4'h3: seg_o_c = 7'h06;
            4'h4: seg_o_c = 7'h4C;
            4'h5: seg_o_c = 7'h24;
            4'h6: seg_o_c = 7'h20;
            4'h7: seg_o_c = 7'h0F;
            4'h8: seg_o_c = 7'h00;
            4'h9: seg_o_c = 7'h04;
            4'hA: seg_o_c = 7'h08;
            4'hB: seg_o_c = 7'h60;
            4'hC: seg_o_c = 7'h31;
            4'hD: seg_o_c = 7'h42;
            4'hE: seg_o_c = 7'h30;
            4'hF: seg_o_c = 7'h38;
            default: seg_o_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with dead-time and frame-aligned updates.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [6:0]            segments,
    output logic                  frame_done
);

    localparam int unsigned VAL_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(max3(PRESCALE, DEAD_CYC, 2));
    localparam int unsigned DIG_W = $clog2(max3(N_DIGITS, 2, 2));
    localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((DEAD_CYC == 0) ? 0 : DEAD_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

    seg_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic [VAL_W-1:0]     disp_q, disp_d;
    logic [VAL_W-1:0]     pend_q, pend_d;
    logic [N_DIGITS-1:0]  anodes_q, anodes_d;
    logic [6:0]           segments_q, segments_d;
    logic                 frame_done_q, frame_done_d;
    logic                 advance, boundary;

    logic [3:0]           nibble;
    logic [6:0]           dec_seg;
    logic [N_DIGITS-1:0]  show;
    logic                 lit;

    // Sequencing, counter, digit index and double-buffer update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        boundary     = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
                DRIVE: begin
                    if (cnt_q == DRV_LAST) begin
                        cnt_d = '0;
                        if (DEAD_CYC == 0) advance = 1'b1;
                        else               state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = DRIVE;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
            if (digit_q == DIG_LAST) begin
                digit_d  = '0;
                boundary = 1'b1;
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end

        if (boundary) begin
            disp_d       = pend_q;
            frame_done_d = 1'b1;
        end

        // A load that coincides with a frame start bypasses the pending buffer
        if (load) begin
            pend_d = value;
            if (boundary || state_q == IDLE) disp_d = value;
        end
    end

    // Which digits are visible
    always_comb begin
        show = '1;
`ifdef SEG_LZ_BLANK_EN
        begin
            logic any_nz;
            any_nz = 1'b0;
            for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
                any_nz  = any_nz | (|disp_d[4*i +: 4]);
                show[i] = any_nz | (i == 0);
            end
        end
`endif
    end

    // Digit mux feeding the shared decoder; outputs follow the next state
    always_comb begin
        nibble     = '0;
        lit        = 1'b0;
        anodes_d   = ANODES_OFF[N_DIGITS-1:0];
        segments_d = SEG_DARK;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (digit_d == DIG_W'(i)) begin
                nibble = disp_d[4*i +: 4];
                lit    = (state_d == DRIVE) && show[i];
                anodes_d[i] = !((state_d == DRIVE) && show[i]);
            end
        end
        if (lit) segments_d = dec_seg;
    end

    bin_hex u_bin_hex (
        .nibble_i (nibble),
        .seg_o_c  (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            digit_q      <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            anodes_q     <= ANODES_OFF[N_DIGITS-1:0];
            segments_q   <= SEG_DARK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anodes     = anodes_q;
    assign segments   = segments_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (N_DIGITS=4, PRESCALE=4, DEAD_CYC=1); honours SEG_LZ_BLANK_EN.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        frame_done;

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [6];

    seg_scan_ctrl #(
        .N_DIGITS (4),
        .PRESCALE (4),
        .DEAD_CYC (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .anodes     (anodes),
        .segments   (segments),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] exp_s;
        logic [3:0] exp_a;
        logic [3:0] one;

        checks = 0;
        errors = 0;
        one    = 4'h1;

        vecs[0] = '{16'h1234, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[1] = '{16'hABCD, {7'h08, 7'h60, 7'h31, 7'h42}};
`ifdef SEG_LZ_BLANK_EN
        vecs[2] = '{16'h0050, {7'h7F, 7'h7F, 7'h24, 7'h01}};
        vecs[3] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
`else
        vecs[2] = '{16'h0050, {7'h01, 7'h01, 7'h24, 7'h01}};
        vecs[3] = '{16'h0000, {7'h01, 7'h01, 7'h01, 7'h01}};
`endif
        vecs[4] = '{16'hEF98, {7'h30, 7'h38, 7'h04, 7'h00}};
        vecs[5] = '{16'h7600, {7'h0F, 7'h20, 7'h01, 7'h01}};

        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        value  = '0;

        #12;
        chk("reset_anodes", 32'(anodes), 32'h0F);
        chk("reset_segments", 32'(segments), 32'h7F);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk("idle_anodes", 32'(anodes), 32'h0F);
        chk("idle_segments", 32'(segments), 32'h7F);

        // Table: load in IDLE together with enable, then walk one full frame
        for (int v = 0; v < 6; v++) begin
            enable = 1'b0;
            tick(1);
            load   = 1'b1;
            value  = vecs[v].value;
            enable = 1'b1;
            tick(1);
            load   = 1'b0;
            chk($sformatf("vec%0d_start_fd", v), 32'(frame_done), 32'h0);
            for (int d = 0; d < 4; d++) begin
                exp_s = vecs[v].seg[d];
                exp_a = (exp_s == 7'h7F) ? 4'hF : (4'hF & ~(one << d));
                chk($sformatf("vec%0d_d%0d_anodes", v, d), 32'(anodes), 32'(exp_a));
                chk($sformatf("vec%0d_d%0d_segments", v, d), 32'(segments), 32'(exp_s));
                tick(4);
                chk($sformatf("vec%0d_d%0d_gap", v, d), 32'(anodes), 32'h0F);
                tick(1);
            end
            chk($sformatf("vec%0d_boundary_fd", v), 32'(frame_done), 32'h1);
            chk($sformatf("vec%0d_boundary_seg", v), 32'(segments), 32'(vecs[v].seg[0]));
        end

        // Mid-frame load waits for the frame boundary
        enable = 1'b0;
        tick(1);
        load   = 1'b1;
        value  = 16'h1234;
        enable = 1'b1;
        tick(1);
        load = 1'b0;
        tick(6);
        load  = 1'b1;
        value = 16'hABCD;
        tick(1);
        load = 1'b0;
        tick(3);
        chk("midload_d2_anodes", 32'(anodes), 32'h0B);
        chk("midload_d2_seg", 32'(segments), 32'h12);
        tick(5);
        chk("midload_d3_seg", 32'(segments), 32'h4F);
        tick(5);
        chk("midload_boundary_fd", 32'(frame_done), 32'h1);
        chk("midload_boundary_anodes", 32'(anodes), 32'h0E);
        chk("midload_boundary_seg", 32'(segments), 32'h42);
        tick(1);
        chk("midload_fd_one_cycle", 32'(frame_done), 32'h0);

        // Two loads in one frame: the last one wins
        tick(3);
        load  = 1'b1;
        value = 16'h1111;
        tick(1);
        load = 1'b0;
        tick(4);
        load  = 1'b1;
        value = 16'h2222;
        tick(1);
        load = 1'b0;
        tick(9);
        chk("lastwins_pre_fd", 32'(frame_done), 32'h0);
        tick(1);
        chk("lastwins_fd", 32'(frame_done), 32'h1);
        chk("lastwins_d0_seg", 32'(segments), 32'h12);
        tick(5);
        chk("lastwins_d1_anodes", 32'(anodes), 32'h0D);
        chk("lastwins_d1_seg", 32'(segments), 32'h12);

        // Load on the boundary cycle is shown straight away
        tick(14);
        load  = 1'b1;
        value = 16'h5555;
        tick(1);
        load = 1'b0;
        chk("bndload_fd", 32'(frame_done), 32'h1);
        chk("bndload_d0_seg", 32'(segments), 32'h24);

        // Disable during the last GAP: no frame_done, restart at digit 0
        tick(19);
        chk("dis_in_gap", 32'(anodes), 32'h0F);
        enable = 1'b0;
        tick(1);
        chk("dis_anodes", 32'(anodes), 32'h0F);
        chk("dis_segments", 32'(segments), 32'h7F);
        chk("dis_fd", 32'(frame_done), 32'h0);
        tick(2);
        chk("dis_fd_later", 32'(frame_done), 32'h0);
        enable = 1'b1;
        tick(1);
        chk("reen_anodes", 32'(anodes), 32'h0E);
        chk("reen_seg_kept", 32'(segments), 32'h24);
        chk("reen_fd", 32'(frame_done), 32'h0);

        // Asynchronous reset in the middle of a DRIVE slot
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_anodes", 32'(anodes), 32'h0F);
        chk("async_rst_segments", 32'(segments), 32'h7F);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        tick(2);
        chk("post_rst_dark", 32'(anodes), 32'h0F);
        enable = 1'b1;
        tick(1);
        chk("post_rst_anodes", 32'(anodes), 32'h0E);
        chk("post_rst_disp_cleared", 32'(segments), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
